// File: rtl/execute_mul_unit_pkg.sv
// Shared Y86-64 execute-stage constants: icodes, ALU functions, conditions,
// status codes, condition-code bit positions and the multiply FSM states.
package execute_mul_unit_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] ALUADD = 4'h0;
   localparam logic [3:0] ALUSUB = 4'h1;
   localparam logic [3:0] ALUAND = 4'h2;
   localparam logic [3:0] ALUXOR = 4'h3;
   localparam logic [3:0] ALUMUL = 4'h4;

   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   localparam logic [3:0] RNONE = 4'hF;

   localparam logic [2:0] SBUB = 3'd0;
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SADR = 3'd2;
   localparam logic [2:0] SINS = 3'd3;
   localparam logic [2:0] SHLT = 3'd4;

   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;
   localparam logic [2:0] CC_RESET = 3'b100;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_MUL  = 2'd1,
      MS_DONE = 2'd2
   } mul_state_e;

   function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
      logic zf, lt, res;
      zf  = cc[CC_ZF];
      lt  = cc[CC_SF] ^ cc[CC_OF];
      res = 1'b0;
      case (fn)
         C_YES:   res = 1'b1;
         C_LE:    res = lt | zf;
         C_L:     res = lt;
         C_E:     res = zf;
         C_NE:    res = ~zf;
         C_GE:    res = ~lt;
         C_G:     res = ~lt & ~zf;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/execute_mul_unit_iter_mul.sv
// exe_iter_mul: shift-add multiplier, one multiplier bit per cycle.
// EXE_EARLY_TERM_EN stops once the remaining multiplier bits are all zero.
module exe_iter_mul
   import execute_mul_unit_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [XLEN-1:0] multiplicand_i,
   input  logic [XLEN-1:0] multiplier_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] product_o
);

   mul_state_e      state_q, state_d;
   logic [XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;
   logic [XLEN-1:0] prod_q, prod_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            last_iter;

`ifdef EXE_EARLY_TERM_EN
   // Unsigned shift-add gives the right low half, so leftover zero bits add nothing.
   assign last_iter = (mplier_q[XLEN-1:1] == '0) || (cnt_q == CNT_W'(XLEN - 1));
`else
   assign last_iter = (cnt_q == CNT_W'(XLEN - 1));
`endif

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      case (state_q)
         MS_IDLE: begin
            if (start_i) begin
               mcand_d  = multiplicand_i;
               mplier_d = multiplier_i;
               prod_d   = '0;
               cnt_d    = '0;
               state_d  = MS_MUL;
            end
         end
         MS_MUL: begin
            if (mplier_q[0]) prod_d = prod_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_iter) state_d = MS_DONE;
         end
         MS_DONE: state_d = MS_IDLE;
         default: state_d = MS_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= MS_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy_o    = (state_q == MS_MUL);
   assign done_o    = (state_q == MS_DONE);
   assign product_o = prod_q;

endmodule

// File: rtl/execute_mul_unit.sv
// Y86-64 execute stage: single-cycle ALU, iterative MUL with stall handshake and
// status-gated CC register. Optional EXE_EARLY_TERM_EN shortens multiplies.
module execute_mul_unit
   import execute_mul_unit_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   input  logic [3:0]      icode_i,
   input  logic [3:0]      ifun_i,
   input  logic [3:0]      dstE_i,
   input  logic [XLEN-1:0] valA_i,
   input  logic [XLEN-1:0] valB_i,
   input  logic [XLEN-1:0] valC_i,
   input  logic            set_cc_i,
   input  logic [2:0]      m_stat_i,
   input  logic [2:0]      W_stat_i,
   output logic [XLEN-1:0] valE_o,
   output logic [3:0]      dstE_o,
   output logic            Cnd_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [2:0]      cc_o
);

   logic [XLEN-1:0] aluA, aluB, alu_res, mul_prod, res_val;
   logic [3:0]      alufun;
   logic            is_opq, mul_start, mul_busy, mul_done, mul_idle, single;
   logic            cc_wr;
   logic [2:0]      cc_q, cc_d;

   always_comb begin
      aluA = '0;
      aluB = '0;
      case (icode_i)
         IRRMOVQ, IOPQ:             aluA = valA_i;
         IIRMOVQ, IRMMOVQ, IMRMOVQ: aluA = valC_i;
         ICALL, IPUSHQ:             aluA = -(XLEN'(8));
         IRET, IPOPQ:               aluA = XLEN'(8);
         default:                   aluA = '0;
      endcase
      case (icode_i)
         IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IPUSHQ, IRET, IPOPQ: aluB = valB_i;
         default:                                            aluB = '0;
      endcase
   end

   assign is_opq = (icode_i == IOPQ);
   assign alufun = is_opq ? ifun_i : ALUADD;

   // ifun above MUL falls into the ADD default.
   always_comb begin
      case (alufun)
         ALUSUB:  alu_res = aluB - aluA;
         ALUAND:  alu_res = aluB & aluA;
         ALUXOR:  alu_res = aluB ^ aluA;
         default: alu_res = aluB + aluA;
      endcase
   end

   assign mul_idle  = !mul_busy && !mul_done;
   assign mul_start = valid_i && is_opq && (ifun_i == ALUMUL) && mul_idle;
   assign single    = mul_idle && !mul_start;

   exe_iter_mul #(.XLEN(XLEN), .CNT_W(CNT_W)) u_mul (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (mul_start),
      .multiplicand_i (aluB),
      .multiplier_i   (aluA),
      .busy_o         (mul_busy),
      .done_o         (mul_done),
      .product_o      (mul_prod)
   );

   assign res_val = mul_done ? mul_prod : alu_res;

   always_comb begin
      cc_d        = '0;
      cc_d[CC_ZF] = (res_val == '0);
      cc_d[CC_SF] = res_val[XLEN-1];
      case (alufun)
         ALUADD:  cc_d[CC_OF] = (aluA[XLEN-1] == aluB[XLEN-1]) &&
                                (res_val[XLEN-1] != aluA[XLEN-1]);
         ALUSUB:  cc_d[CC_OF] = (aluB[XLEN-1] != aluA[XLEN-1]) &&
                                (res_val[XLEN-1] != aluB[XLEN-1]);
         default: cc_d[CC_OF] = 1'b0;
      endcase
   end

   // Only a faulting-free downstream lets an OPQ touch the flags.
   assign cc_wr = valid_i && is_opq && set_cc_i &&
                  (m_stat_i == SAOK) && (W_stat_i == SAOK) &&
                  ((single && (ifun_i <= ALUXOR)) || mul_done);

   always_ff @(posedge clk_i) begin
      if (rst_i)      cc_q <= CC_RESET;
      else if (cc_wr) cc_q <= cc_d;
   end

   assign cc_o   = cc_q;
   assign busy_o = valid_i && (mul_start || mul_busy);
   assign done_o = valid_i && (single || mul_done);
   assign valE_o = (valid_i && (single || mul_done)) ? res_val : '0;
   assign Cnd_o  = valid_i && cond_eval(ifun_i, cc_q);
   assign dstE_o = (!valid_i || (icode_i == IRRMOVQ && !Cnd_o)) ? RNONE : dstE_i;

   // A multiply in flight owns the stage; its instruction must not change under it.
   a_mul_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      mul_busy |-> (valid_i && is_opq && ifun_i == ALUMUL));

endmodule

// File: tb/tb_execute_mul_unit.sv
// Bench for execute_mul_unit: vector table for single-cycle ops, scoreboarded
// multiplies (XLEN=64 and XLEN=16), back-to-back MULs and reset mid-multiply.
module tb_execute_mul_unit;
   import execute_mul_unit_pkg::*;

`ifdef EXE_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk, rst;
   logic        valid, v16;
   logic [3:0]  icode, ifun, dst;
   logic [63:0] va, vb, vc;
   logic [15:0] a16, b16, c16;
   logic        setcc;
   logic [2:0]  mstat, wstat;
   logic [63:0] valE;
   logic [3:0]  dstE;
   logic        cnd, busy, done;
   logic [2:0]  cc;
   logic [15:0] valE16;
   logic [3:0]  dstE16;
   logic        cnd16, busy16, done16;
   logic [2:0]  cc16;

   execute_mul_unit #(.XLEN(64)) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .icode_i(icode), .ifun_i(ifun),
      .dstE_i(dst), .valA_i(va), .valB_i(vb), .valC_i(vc), .set_cc_i(setcc),
      .m_stat_i(mstat), .W_stat_i(wstat), .valE_o(valE), .dstE_o(dstE),
      .Cnd_o(cnd), .busy_o(busy), .done_o(done), .cc_o(cc));

   execute_mul_unit #(.XLEN(16)) dut16 (
      .clk_i(clk), .rst_i(rst), .valid_i(v16), .icode_i(icode), .ifun_i(ifun),
      .dstE_i(dst), .valA_i(a16), .valB_i(b16), .valC_i(c16), .set_cc_i(setcc),
      .m_stat_i(mstat), .W_stat_i(wstat), .valE_o(valE16), .dstE_o(dstE16),
      .Cnd_o(cnd16), .busy_o(busy16), .done_o(done16), .cc_o(cc16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  icode, ifun;
      logic [63:0] a, b, c;
      logic [3:0]  dst;
      logic        setcc;
      logic [2:0]  mstat, wstat;
      logic [63:0] e_val;
      logic [3:0]  e_dst;
      logic        e_cnd;
      logic [2:0]  e_cc;
   } vec_t;

   typedef struct {
      logic [63:0] val;
      logic [3:0]  dst;
   } exp_t;

   vec_t vt[16];
   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;

   localparam logic [63:0] MAX = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

   task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
   endtask

   function automatic int exp_lat(input logic [63:0] a, input int w);
      int hi;
      hi = 0;
      for (int i = 0; i < w; i++) if (a[i]) hi = i + 1;
      if (EARLY) return ((hi < 1) ? 1 : hi) + 1;
      return w + 1;
   endfunction

   // Starts a MUL at posedge+1, counts busy cycles until done, checks result and flags.
   task automatic run_mul(input bit w16, input logic [63:0] a, input logic [63:0] b, input int id);
      logic [63:0] ev;
      logic [2:0]  ecc;
      int w, lat, got, nb;
      exp_t e;
      w  = w16 ? 16 : 64;
      ev = a * b;
      if (w16) ev = {48'd0, ev[15:0]};
      lat = exp_lat(a, w);
      ecc = {ev == 64'd0, ev[w-1], 1'b0};
      icode = IOPQ; ifun = ALUMUL; dst = 4'd5; setcc = 1'b1; mstat = SAOK; wstat = SAOK;
      if (w16) begin v16 = 1'b1; a16 = a[15:0]; b16 = b[15:0]; end
      else begin valid = 1'b1; va = a; vb = b; end
      sb.push_back('{ev, 4'd5});
      got = -1; nb = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (w16 ? done16 : done) begin got = c; break; end
         if (w16 ? busy16 : busy) nb++;
         @(posedge clk); #1;
      end
      chk("mul_latency", id, 64'(got), 64'(lat));
      chk("mul_busy_cycles", id, 64'(nb), 64'(lat));
      chk("mul_busy_at_done", id, 64'(w16 ? busy16 : busy), 64'd0);
      e = sb.pop_front();
      chk("mul_valE", id, w16 ? {48'd0, valE16} : valE, e.val);
      chk("mul_dstE", id, 64'(w16 ? dstE16 : dstE), 64'(e.dst));
      @(posedge clk); #1;
      chk("mul_cc", id, 64'(w16 ? cc16 : cc), 64'(ecc));
   endtask

   initial begin
      exp_t e;
      vt[0]  = '{IRRMOVQ, C_LE,   64'h11, 64'd0,   64'd0,     4'd3, 1'b0, SAOK, SAOK, 64'h11,   4'd3,  1'b1, 3'b100};
      vt[1]  = '{IOPQ,    ALUSUB, 64'd3,  64'd5,   64'd0,     4'd4, 1'b1, SAOK, SAOK, 64'd2,    4'd4,  1'b1, 3'b000};
      vt[2]  = '{IRRMOVQ, C_LE,   64'h11, 64'd0,   64'd0,     4'd3, 1'b0, SAOK, SAOK, 64'h11,   RNONE, 1'b0, 3'b000};
      vt[3]  = '{IOPQ,    ALUADD, MAX,    64'd1,   64'd0,     4'd5, 1'b1, SAOK, SAOK, MIN,      4'd5,  1'b1, 3'b011};
      vt[4]  = '{IOPQ,    ALUADD, 64'd1,  64'd1,   64'd0,     4'd5, 1'b1, SADR, SAOK, 64'd2,    4'd5,  1'b1, 3'b011};
      vt[5]  = '{IOPQ,    ALUAND, 64'hF0, 64'h3C,  64'd0,     4'd6, 1'b1, SAOK, SAOK, 64'h30,   4'd6,  1'b0, 3'b000};
      vt[6]  = '{IOPQ,    ALUXOR, 64'd5,  64'd5,   64'd0,     4'd7, 1'b1, SAOK, SAOK, 64'd0,    4'd7,  1'b0, 3'b100};
      vt[7]  = '{IIRMOVQ, C_YES,  64'd0,  64'd99,  64'h1234,  4'd8, 1'b1, SAOK, SAOK, 64'h1234, 4'd8,  1'b1, 3'b100};
      vt[8]  = '{IMRMOVQ, C_YES,  64'd0,  64'h100, 64'h10,    4'd9, 1'b0, SAOK, SAOK, 64'h110,  4'd9,  1'b1, 3'b100};
      vt[9]  = '{IPUSHQ,  C_YES,  64'd0,  64'h200, 64'd0,     4'd4, 1'b0, SAOK, SAOK, 64'h1F8,  4'd4,  1'b1, 3'b100};
      vt[10] = '{IPOPQ,   C_YES,  64'd0,  64'h200, 64'd0,     4'd4, 1'b0, SAOK, SAOK, 64'h208,  4'd4,  1'b1, 3'b100};
      vt[11] = '{IOPQ,    4'd7,   64'd2,  64'd3,   64'd0,     4'd2, 1'b1, SAOK, SAOK, 64'd5,    4'd2,  1'b0, 3'b100};
      vt[12] = '{IOPQ,    ALUSUB, 64'd1,  MIN,     64'd0,     4'd1, 1'b1, SAOK, SAOK, MAX,      4'd1,  1'b1, 3'b001};
      vt[13] = '{IJXX,    C_L,    64'd0,  64'd0,   64'd0,     RNONE,1'b0, SAOK, SAOK, 64'd0,    RNONE, 1'b1, 3'b001};
      vt[14] = '{ICALL,   C_YES,  64'd0,  64'h100, 64'd0,     RNONE,1'b1, SAOK, SAOK, 64'hF8,   RNONE, 1'b1, 3'b001};
      vt[15] = '{IOPQ,    ALUSUB, 64'd3,  64'd3,   64'd0,     4'd2, 1'b1, SAOK, SHLT, 64'd0,    4'd2,  1'b1, 3'b001};

      rst = 1'b1; valid = 1'b0; v16 = 1'b0;
      icode = INOP; ifun = 4'd0; dst = 4'd0; setcc = 1'b0; mstat = SAOK; wstat = SAOK;
      va = '0; vb = '0; vc = '0; a16 = '0; b16 = '0; c16 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_cc", 0, 64'(cc), 64'(3'b100));
      chk("rst_cc16", 0, 64'(cc16), 64'(3'b100));
      chk("idle_busy", 0, 64'(busy), 64'd0);
      chk("idle_done", 0, 64'(done), 64'd0);
      chk("idle_valE", 0, valE, 64'd0);
      chk("idle_dstE", 0, 64'(dstE), 64'(RNONE));
      chk("idle_cnd", 0, 64'(cnd), 64'd0);
      chk("idle_cnd16", 0, 64'(cnd16), 64'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) begin
         icode = vt[i].icode; ifun = vt[i].ifun; va = vt[i].a; vb = vt[i].b; vc = vt[i].c;
         dst = vt[i].dst; setcc = vt[i].setcc; mstat = vt[i].mstat; wstat = vt[i].wstat;
         valid = 1'b1;
         sb.push_back('{vt[i].e_val, vt[i].e_dst});
         @(negedge clk);
         chk("vec_done", i, 64'(done), 64'd1);
         e = sb.pop_front();
         chk("vec_valE", i, valE, e.val);
         chk("vec_dstE", i, 64'(dstE), 64'(e.dst));
         chk("vec_cnd", i, 64'(cnd), 64'(vt[i].e_cnd));
         @(posedge clk); #1;
         chk("vec_cc", i, 64'(cc), 64'(vt[i].e_cc));
      end

      // Three back-to-back multiplies, each starting the cycle after the previous DONE.
      run_mul(1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFF9, 0);
      run_mul(1'b0, 64'd0, 64'd5, 1);
      run_mul(1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFF9, 2);

      // Reset lands in cycle 10 of a multiply.
      icode = IOPQ; ifun = ALUMUL; setcc = 1'b1; va = 64'hFFFF; vb = 64'd3; valid = 1'b1;
      for (int c = 1; c <= 10; c++) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(negedge clk);
      chk("rstmul_busy_before", 0, 64'(busy), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0; valid = 1'b0;
      @(negedge clk);
      chk("rstmul_busy", 0, 64'(busy), 64'd0);
      chk("rstmul_done", 0, 64'(done), 64'd0);
      chk("rstmul_cc", 0, 64'(cc), 64'(3'b100));
      @(posedge clk); #1;
      icode = IOPQ; ifun = ALUADD; setcc = 1'b0; va = 64'd2; vb = 64'd3; dst = 4'd6; valid = 1'b1;
      sb.push_back('{64'd5, 4'd6});
      @(negedge clk);
      chk("rstmul_next_done", 0, 64'(done), 64'd1);
      e = sb.pop_front();
      chk("rstmul_next_valE", 0, valE, e.val);
      chk("rstmul_next_busy", 0, 64'(busy), 64'd0);
      @(posedge clk); #1;
      valid = 1'b0;

      run_mul(1'b1, 64'd3, 64'hFFF9, 3);
      run_mul(1'b1, 64'h0100, 64'h0100, 4);
      v16 = 1'b0;
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
